test_read_multi: RTL
====================

Name: test_read_multi

Overview:
FIFO-side reader that consumes the multi-byte records produced by the team's FIFO writer blocks. Handshakes with a standard-mode (non-FWFT) FIFO read port. Checks a header byte, assembles PAYLOAD_BYTES payload bytes into one word, and signals done or a classified error. Sits on the read side of the sensor-module FIFO, paired with the writer on the write side.

Parameters:
PAYLOAD_BYTES, 2, number of payload bytes after the header (1..4)
HEADER, 8'hAA, required first byte of every record
TIMEOUT, 16, max cycles to wait for valid after a read_en pulse before error

Ports:
clk  input  1  system clock, all logic on posedge
reset  input  1  synchronous, active-high reset
start  input  1  begin reading one record (sampled in S_IDLE)
restart  input  1  return from S_DONE/S_ERROR to S_IDLE
data_in  input  8  FIFO dout
empty  input  1  FIFO empty flag
valid  input  1  FIFO dout valid (1 cycle after accepted rd_en)
underflow  input  1  FIFO underflow flag
read_en  output  1  FIFO rd_en, single-cycle pulses
payload  output  8*PAYLOAD_BYTES  assembled payload, first byte in MSBs
done  output  1  one-cycle pulse when a good record has been read
error  output  1  level, high while in S_ERROR
err_code  output  2  0 none, 1 header mismatch, 2 underflow, 3 timeout (or checksum, see below)

Behaviour:
- Interface: one clock (clk); reset is synchronous and active-high.
- Reset: state S_IDLE; read_en=0, done=0, error=0, err_code=0, payload=0, byte counter=0, timeout counter=0.
- reset has priority over everything. underflow in any state except S_IDLE, S_DONE and S_ERROR -> S_ERROR, err_code=2.
- S_IDLE: start=1 -> S_REQ, byte counter cleared. payload holds its last value.
- S_REQ: if !empty, drive read_en=1 for exactly one cycle and go to S_WAIT. If empty, stay with read_en=0. There are no cycle limits in S_REQ.
- S_WAIT: read_en=0. Timeout counter increments each cycle.
  - valid=1 with byte index 0: data_in!=HEADER -> S_ERROR, err_code=1. Otherwise accept the byte.
  - valid=1 with index 1..PAYLOAD_BYTES: shift the byte into payload, payload <= {payload[8*PAYLOAD_BYTES-9:0], data_in}.
  - After accepting a byte: if it was the last byte, go to S_DONE. Otherwise increment the index and go to S_REQ.
  - Counter reaching TIMEOUT without valid -> S_ERROR, err_code=3.
- At most one outstanding read. read_en is never asserted while empty=1 or in S_WAIT.
- Byte timing: the fastest byte takes 2 cycles (REQ, WAIT with valid). The minimum record latency from start is 2*(PAYLOAD_BYTES+1)+1 cycles to the done pulse.
- S_DONE: done=1 for the first cycle only (entry pulse). Then hold. restart -> S_IDLE. A start in S_DONE is ignored.
- S_ERROR: error=1 and err_code held. payload keeps the bytes accepted so far. restart -> S_IDLE, which clears error and err_code.
- valid=1 outside S_WAIT is ignored (no state change, no capture).
- start and restart asserted together in S_DONE: restart wins, and start is not seen until the next S_IDLE cycle.

Optional Feature:
CHECKSUM_EN
- Defined: after the last payload byte, one more byte is read (REQ/WAIT as above). It must equal the XOR of the header and all payload bytes.
  - Match -> S_DONE.
  - Mismatch -> S_ERROR with err_code=3 (a timeout reports as 3 as well). A sticky internal flag distinguishes the two for debug only.
  - Minimum latency grows by 2 cycles.
- Undefined: no checksum byte; behaviour exactly as above.

Decomposition:
- Shared package test_multi_pkg holds:
  - state encodings: S_IDLE, S_REQ, S_WAIT, S_DONE, S_ERROR (3-bit)
  - err_code constants: ERR_NONE, ERR_HEADER, ERR_UNDERFLOW, ERR_TIMEOUT
  - default HEADER 8'hAA, so reader and writer share one definition.
- One natural sub-module: fifo_rd_timer (loadable down-counter with expire flag) for the S_WAIT timeout. Everything else stays in the top FSM.

Test Plan:
- FIFO preloaded AA 12 34, valid 1 cycle after each read_en, start pulse -> exactly 3 read_en pulses, payload=16'h1234, done high 1 cycle at cycle 7 after start, error=0.
- FIFO preloaded 55 12 34 -> 1 read_en pulse, S_ERROR, error=1, err_code=1, no done; restart -> error=0, err_code=0.
- empty held 1 for 20 cycles after start, then AA 12 34 arrives -> read_en stays 0 while empty, then record completes with payload=16'h1234.
- valid withheld 16 cycles after the second read_en -> error=1, err_code=3; payload low byte=8'h00 (no payload byte was accepted).
- underflow pulse during S_WAIT of byte 2 -> error=1, err_code=2 next cycle; reset asserted mid-record -> all outputs return to their reset values the following cycle.
- CHECKSUM_EN defined, FIFO AA 12 34 8C -> done, payload=16'h1234; FIFO AA 12 34 00 -> error=1, err_code=3.

Source files
------------

// File: rtl/test_multi_pkg.sv
// Shared definitions for the multi-byte FIFO record reader and writer:
// FSM state encodings, error codes and the default record header byte.
package test_multi_pkg;

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_REQ   = 3'd1,
    S_WAIT  = 3'd2,
    S_DONE  = 3'd3,
    S_ERROR = 3'd4
  } state_t;

  localparam logic [1:0] ERR_NONE      = 2'd0;
  localparam logic [1:0] ERR_HEADER    = 2'd1;
  localparam logic [1:0] ERR_UNDERFLOW = 2'd2;
  localparam logic [1:0] ERR_TIMEOUT   = 2'd3;

  localparam logic [7:0] DEFAULT_HEADER = 8'hAA;

endpackage

// File: rtl/test_read_multi_fifo_rd_timer.sv
// Loadable down-counter used as the read-response timeout.
// o_expired is high whenever the count is zero; the counter stops at zero.
module fifo_rd_timer #(
  parameter int W = 5
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         i_load,
  input  logic [W-1:0] i_load_val,
  input  logic         i_en,
  output logic         o_expired
);

  logic [W-1:0] r_count;

  // Load takes priority over counting down; hold at zero once reached.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_count <= '0;
    end else if (i_load) begin
      r_count <= i_load_val;
    end else if (i_en && (r_count != '0)) begin
      r_count <= r_count - 1'b1;
    end
  end

  assign o_expired = (r_count == '0);

endmodule

// File: rtl/test_read_multi.sv
// Reader for multi-byte records on a standard-mode (non-FWFT) FIFO read port.
// Record: HEADER, then PAYLOAD_BYTES payload bytes (first byte ends in MSBs).
// Optional feature macro CHECKSUM_EN: an extra trailing byte that must equal
// the XOR of header and payload; a mismatch reports as ERR_TIMEOUT.
// FIFO handshake: read_en is a one-cycle request issued only in S_REQ while
// !empty; the FIFO answers with valid one or more cycles later, at most one
// request is ever outstanding, and valid is ignored outside S_WAIT.
module test_read_multi
  import test_multi_pkg::*;
#(
  parameter int         PAYLOAD_BYTES = 2,
  parameter logic [7:0] HEADER        = DEFAULT_HEADER,
  parameter int         TIMEOUT       = 16
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       start,
  input  logic                       restart,
  input  logic [7:0]                 data_in,
  input  logic                       empty,
  input  logic                       valid,
  input  logic                       underflow,
  output logic                       read_en,
  output logic [8*PAYLOAD_BYTES-1:0] payload,
  output logic                       done,
  output logic                       error,
  output logic [1:0]                 err_code,
  output logic [2:0]                 dbg_state,
  output logic                       dbg_csum_err
);

  localparam int PW = 8 * PAYLOAD_BYTES;
  localparam int TW = $clog2(TIMEOUT + 1);
`ifdef CHECKSUM_EN
  localparam logic [2:0] LAST_IDX = 3'(PAYLOAD_BYTES + 1);
`else
  localparam logic [2:0] LAST_IDX = 3'(PAYLOAD_BYTES);
`endif
  localparam logic [2:0] PAY_LAST = 3'(PAYLOAD_BYTES);

  state_t        r_state;
  state_t        w_next;
  logic [2:0]    r_idx;
  logic [PW-1:0] r_payload;
  logic [1:0]    r_err_code;
  logic          r_done;
  logic          w_rd;
  logic          w_accept;
  logic          w_set_err;
  logic [1:0]    w_err_val;
  logic          w_expired;
  logic [PW+7:0] w_wide;
  logic [PW-1:0] w_shift;
`ifdef CHECKSUM_EN
  logic [7:0]    r_xor;
  logic          r_csum_err;
  logic          w_csum_bad;
`endif

  // Payload shifted left by one byte with data_in entering the LSBs.
  assign w_wide  = {r_payload, data_in};
  assign w_shift = w_wide[PW-1:0];

  fifo_rd_timer #(.W(TW)) u_timer (
    .clk        (clk),
    .reset      (reset),
    .i_load     (w_rd),
    .i_load_val (TW'(TIMEOUT - 1)),
    .i_en       (r_state == S_WAIT),
    .o_expired  (w_expired)
  );

  // Next-state logic, read request and error classification.
  always_comb begin
    w_next    = r_state;
    w_rd      = 1'b0;
    w_accept  = 1'b0;
    w_set_err = 1'b0;
    w_err_val = ERR_NONE;
`ifdef CHECKSUM_EN
    w_csum_bad = 1'b0;
`endif
    case (r_state)
      S_IDLE: begin
        if (start) w_next = S_REQ;
      end
      S_REQ: begin
        if (underflow) begin
          w_set_err = 1'b1;
          w_err_val = ERR_UNDERFLOW;
        end else if (!empty) begin
          w_rd   = 1'b1;
          w_next = S_WAIT;
        end
      end
      S_WAIT: begin
        if (underflow) begin
          w_set_err = 1'b1;
          w_err_val = ERR_UNDERFLOW;
        end else if (valid) begin
          if ((r_idx == 3'd0) && (data_in != HEADER)) begin
            w_set_err = 1'b1;
            w_err_val = ERR_HEADER;
          end
`ifdef CHECKSUM_EN
          else if ((r_idx == LAST_IDX) && (data_in != r_xor)) begin
            w_set_err  = 1'b1;
            w_err_val  = ERR_TIMEOUT;
            w_csum_bad = 1'b1;
          end
`endif
          else begin
            w_accept = 1'b1;
            w_next   = (r_idx == LAST_IDX) ? S_DONE : S_REQ;
          end
        end else if (w_expired) begin
          w_set_err = 1'b1;
          w_err_val = ERR_TIMEOUT;
        end
      end
      S_DONE: begin
        if (restart) w_next = S_IDLE;
      end
      S_ERROR: begin
        if (restart) w_next = S_IDLE;
      end
      default: w_next = S_IDLE;
    endcase
    if (w_set_err) w_next = S_ERROR;
  end

  // State, byte index, payload assembly, done pulse and error code registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state    <= S_IDLE;
      r_idx      <= 3'd0;
      r_payload  <= '0;
      r_err_code <= ERR_NONE;
      r_done     <= 1'b0;
`ifdef CHECKSUM_EN
      r_xor      <= 8'h00;
      r_csum_err <= 1'b0;
`endif
    end else begin
      r_state <= w_next;
      r_done  <= (w_next == S_DONE) && (r_state != S_DONE);
      if ((r_state == S_IDLE) && start) begin
        r_idx <= 3'd0;
`ifdef CHECKSUM_EN
        r_xor <= 8'h00;
`endif
      end
      if (w_accept) begin
        r_idx <= r_idx + 3'd1;
        if ((r_idx != 3'd0) && (r_idx <= PAY_LAST)) r_payload <= w_shift;
`ifdef CHECKSUM_EN
        r_xor <= r_xor ^ data_in;
`endif
      end
      if (w_set_err) begin
        r_err_code <= w_err_val;
      end else if ((r_state == S_ERROR) && (w_next == S_IDLE)) begin
        r_err_code <= ERR_NONE;
      end
`ifdef CHECKSUM_EN
      if (w_csum_bad) r_csum_err <= 1'b1;
`endif
    end
  end

  assign read_en   = w_rd;
  assign payload   = r_payload;
  assign done      = r_done;
  assign error     = (r_state == S_ERROR);
  assign err_code  = r_err_code;
  assign dbg_state = r_state;
`ifdef CHECKSUM_EN
  assign dbg_csum_err = r_csum_err;
`else
  assign dbg_csum_err = 1'b0;
`endif

endmodule
